// File: rtl/led_fader_if.sv
// LED pattern bus between the pattern source and the fader.
// Ports:
//   led_in  : target pattern, 1 = fade toward on, 0 = fade toward off
//   led_out : PWM-dimmed LED drive
interface led_fader_if #(
  parameter int unsigned CHANNELS = 8
);
  logic [CHANNELS-1:0] led_in;
  logic [CHANNELS-1:0] led_out;

  // Pattern source / pin side
  modport master (output led_in, input led_out);
  // Fader side
  modport slave  (input led_in, output led_out);
endinterface

// File: rtl/led_fader.sv
// Per-channel LED fader: each channel ramps a brightness level toward full-on
// or full-off according to its input bit and drives its pin with PWM at that
// level, turning hard on/off toggles into smooth fades.
// Ports:
//   clk : 25 MHz main clock
//   rst : synchronous active-high reset
//   bus : led_fader_if slave (led_in target pattern, led_out registered PWM)
module led_fader #(
  parameter int unsigned CHANNELS = 8,
  parameter int unsigned PWM_DIV  = 4,
  parameter int unsigned STEP_DIV = 49152,
  parameter int unsigned STEP     = 1
) (
  input  logic        clk,
  input  logic        rst,
  led_fader_if.slave  bus
);

  localparam int unsigned PDIV_W = (PWM_DIV  > 1) ? $clog2(PWM_DIV)  : 1;
  localparam int unsigned SDIV_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int unsigned LVL_W  = 8;

  logic [CHANNELS-1:0] in_q;
  logic [PDIV_W-1:0]   pdiv;
  logic [SDIV_W-1:0]   sdiv;
  logic [LVL_W-1:0]    pwm_cnt;
  logic [LVL_W-1:0]    level     [CHANNELS];
  logic [LVL_W-1:0]    level_nxt [CHANNELS];
  logic [CHANNELS-1:0] out_q;
  logic [CHANNELS-1:0] out_nxt;
  logic                pwm_tick_c;
  logic                step_tick_c;

  // Prescaler terminal counts; with a divisor of 1 the counter is stuck at 0
  // and the tick fires every cycle.
  assign pwm_tick_c  = (pdiv == PDIV_W'(PWM_DIV - 1));
  assign step_tick_c = (sdiv == SDIV_W'(STEP_DIV - 1));

  // Saturating fade in 9 bits: carry out clamps at 255, borrow clamps at 0.
  always_comb begin
    logic [LVL_W:0] sum;
    logic [LVL_W:0] diff;
    for (int i = 0; i < CHANNELS; i++) begin
      level_nxt[i] = level[i];
      sum  = {1'b0, level[i]} + (LVL_W+1)'(STEP);
      diff = {1'b0, level[i]} - (LVL_W+1)'(STEP);
      if (step_tick_c) begin
        if (in_q[i]) begin
          level_nxt[i] = sum[LVL_W] ? {LVL_W{1'b1}} : sum[LVL_W-1:0];
        end else begin
          level_nxt[i] = diff[LVL_W] ? '0 : diff[LVL_W-1:0];
        end
      end
    end
  end

  // PWM compare; level 255 is forced fully on rather than 255/256 duty.
  always_comb begin
    out_nxt = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      out_nxt[i] = (level[i] == {LVL_W{1'b1}}) || (pwm_cnt < level[i]);
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_q    <= '0;
      pdiv    <= '0;
      sdiv    <= '0;
      pwm_cnt <= '0;
      out_q   <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        level[i] <= '0;
      end
    end else begin
      in_q  <= bus.led_in;
      out_q <= out_nxt;
      pdiv  <= pwm_tick_c  ? '0 : pdiv + PDIV_W'(1);
      sdiv  <= step_tick_c ? '0 : sdiv + SDIV_W'(1);
      if (pwm_tick_c) begin
        pwm_cnt <= pwm_cnt + LVL_W'(1);
      end
      for (int i = 0; i < CHANNELS; i++) begin
        level[i] <= level_nxt[i];
      end
    end
  end

  assign bus.led_out = out_q;

endmodule

// File: tb/tb_led_fader.sv
// Self-checking bench for led_fader: three instances with different
// prescaler/step settings, compared every cycle against a behavioural model
// plus table vectors and hand-derived corner-case sequences.
module tb_led_fader;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_v [3];

  always #20 clk = ~clk;

  led_fader_if #(.CHANNELS(8)) if_a ();
  led_fader_if #(.CHANNELS(8)) if_b ();
  led_fader_if #(.CHANNELS(8)) if_c ();

  assign if_a.led_in = in_v[0];
  assign if_b.led_in = in_v[1];
  assign if_c.led_in = in_v[2];

  led_fader #(.CHANNELS(8), .PWM_DIV(1), .STEP_DIV(4),    .STEP(64))
    u_a (.clk(clk), .rst(rst), .bus(if_a));
  led_fader #(.CHANNELS(8), .PWM_DIV(1), .STEP_DIV(1024), .STEP(64))
    u_b (.clk(clk), .rst(rst), .bus(if_b));
  led_fader #(.CHANNELS(8), .PWM_DIV(3), .STEP_DIV(16),   .STEP(100))
    u_c (.clk(clk), .rst(rst), .bus(if_c));

  int vectors     = 0;
  int miscompares = 0;

  // Behavioural model state: cycles since reset, levels as plain integers.
  int unsigned m_k;
  int          m_lvl [3][8];
  logic [7:0]  m_inq [3];
  logic [7:0]  m_exp [3];
  bit          m_valid = 1'b0;

  function automatic int unsigned cfg_pd(input int d);
    return (d == 2) ? 3 : 1;
  endfunction

  function automatic int unsigned cfg_sd(input int d);
    case (d)
      0:       return 4;
      1:       return 1024;
      default: return 16;
    endcase
  endfunction

  function automatic int cfg_st(input int d);
    return (d == 2) ? 100 : 64;
  endfunction

  function automatic logic [7:0] dut_out(input int d);
    case (d)
      0:       return if_a.led_out;
      1:       return if_b.led_out;
      default: return if_c.led_out;
    endcase
  endfunction

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_step();
    int unsigned pc;
    bit          tick;
    logic [7:0]  nexp;
    if (rst) begin
      m_k = 0;
      for (int d = 0; d < 3; d++) begin
        m_inq[d] = '0;
        m_exp[d] = '0;
        for (int c = 0; c < 8; c++) m_lvl[d][c] = 0;
      end
      m_valid = 1'b1;
    end else if (m_valid) begin
      for (int d = 0; d < 3; d++) begin
        pc   = (m_k / cfg_pd(d)) % 256;
        tick = ((m_k % cfg_sd(d)) == cfg_sd(d) - 1);
        nexp = '0;
        for (int c = 0; c < 8; c++) begin
          nexp[c] = (m_lvl[d][c] == 255) || (int'(pc) < m_lvl[d][c]);
          if (tick) begin
            if (m_inq[d][c]) m_lvl[d][c] = (m_lvl[d][c] + cfg_st(d) > 255) ? 255 : m_lvl[d][c] + cfg_st(d);
            else             m_lvl[d][c] = (m_lvl[d][c] - cfg_st(d) < 0)   ? 0   : m_lvl[d][c] - cfg_st(d);
          end
        end
        m_exp[d] = nexp;
        m_inq[d] = in_v[d];
      end
      m_k++;
    end
  endtask

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      if (miscompares <= 40)
        $display("FAIL %s: got %02h, required %02h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, required %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // One clock: model follows the edge, outputs compared on the falling edge.
  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    if (m_valid) begin
      for (int d = 0; d < 3; d++) check8($sformatf("model_dut%0d", d), dut_out(d), m_exp[d]);
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) cycle();
    rst = 1'b0;
  endtask

  typedef struct {
    bit         rst;
    logic [7:0] ia, ib, ic;
    int         cycles;
    logic [7:0] ea, eb, ec;
  } vec_t;

  vec_t tbl [6];

  initial begin
    int cnt, first, last;
    tbl[0] = '{1'b1, 8'hFF, 8'hFF, 8'hA5, 3,    8'h00, 8'h00, 8'h00};
    tbl[1] = '{1'b0, 8'hFF, 8'hFF, 8'hA5, 400,  8'hFF, 8'h00, 8'hA5};
    tbl[2] = '{1'b0, 8'h00, 8'h00, 8'h5A, 400,  8'h00, 8'h00, 8'h5A};
    tbl[3] = '{1'b0, 8'h3C, 8'h00, 8'h00, 400,  8'h3C, 8'h00, 8'h00};
    tbl[4] = '{1'b1, 8'hFF, 8'hFF, 8'hFF, 2,    8'h00, 8'h00, 8'h00};
    tbl[5] = '{1'b0, 8'hC3, 8'hFF, 8'h81, 1000, 8'hC3, 8'h00, 8'h81};

    // Reset hold with all inputs high, then ramp to saturation.
    rst = 1'b1;
    for (int d = 0; d < 3; d++) in_v[d] = 8'hFF;
    for (int i = 0; i < 20; i++) begin
      cycle();
      check8("reset_hold", dut_out(0), 8'h00);
    end
    rst = 1'b0;
    for (int s = 1; s <= 300; s++) begin
      cycle();
      if (s < 5)       check8("pre_level", dut_out(0), 8'h00);
      else if (s == 5) check8("first_high", dut_out(0), 8'hFF);
      else if (s >= 17) check8("sat_on", dut_out(0), 8'hFF);
    end

    // Single-channel ramp, duty measurement on b, ramp-down clamp on c.
    in_v[0] = 8'h01; in_v[1] = 8'h01; in_v[2] = 8'hFF;
    do_reset(2);
    cnt = 0; first = -1; last = -1;
    for (int s = 1; s <= 1300; s++) begin
      cycle();
      if (s < 5)        check8("ch0_pre", dut_out(0), 8'h00);
      else if (s == 5)  check8("ch0_first", dut_out(0), 8'h01);
      else if (s >= 17) check8("ch0_sat", dut_out(0), 8'h01);
      if (s >= 1025 && s <= 1280 && dut_out(1)[0]) begin
        if (first < 0) first = s;
        last = s;
        cnt++;
      end
      if (s >= 60 && s <= 600) check8("c_full_on", dut_out(2), 8'hFF);
      if (s == 600) in_v[2] = 8'h00;
      if (s >= 650) check8("c_clamp_off", dut_out(2), 8'h00);
    end
    check_int("duty_count", cnt, 64);
    check_int("duty_start", first, 1025);
    check_int("duty_span", last - first + 1, 64);

    // Reset mid-ramp at level 128, then restart.
    in_v[0] = 8'h01;
    do_reset(1);
    repeat (8) cycle();
    rst = 1'b1;
    cycle();
    check8("mid_reset", dut_out(0), 8'h00);
    rst = 1'b0;
    for (int s = 1; s <= 6; s++) begin
      cycle();
      if (s < 5)       check8("restart_pre", dut_out(0), 8'h00);
      else if (s == 5) check8("restart_first", dut_out(0), 8'h01);
    end

    // Table vectors with settled end-state checks.
    for (int v = 0; v < 6; v++) begin
      rst = tbl[v].rst;
      in_v[0] = tbl[v].ia; in_v[1] = tbl[v].ib; in_v[2] = tbl[v].ic;
      repeat (tbl[v].cycles) cycle();
      check8($sformatf("tbl%0d_a", v), dut_out(0), tbl[v].ea);
      check8($sformatf("tbl%0d_b", v), dut_out(1), tbl[v].eb);
      check8($sformatf("tbl%0d_c", v), dut_out(2), tbl[v].ec);
    end
    rst = 1'b0;

    // Random patterns and occasional resets against the model.
    for (int n = 0; n < 4000; ) begin
      int hold;
      hold = $urandom_range(1, 24);
      for (int d = 0; d < 3; d++) in_v[d] = 8'($urandom);
      rst = ($urandom_range(0, 99) == 0);
      cycle();
      rst = 1'b0;
      repeat (hold) cycle();
      n += hold + 1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
